// File: rtl/ram_frame_capture.sv
// Pre/post-trigger capture controller for a 1024x8 SDP RAM with 1-clock registered read.
// Fills a circular buffer until trigger, then replays the frame over valid/ready.
module ram_frame_capture #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRE_TRIG   = 256,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  trig,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] trig_addr
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam int unsigned POST_LEN = DEPTH - PRE_TRIG;
  localparam int unsigned SKID     = RD_LATENCY + 1;
  localparam logic [ADDR_WIDTH-1:0] PRE_A   = ADDR_WIDTH'(PRE_TRIG);
  localparam logic [ADDR_WIDTH-1:0] PRE_M1  = ADDR_WIDTH'(PRE_TRIG - 1);
  localparam logic [ADDR_WIDTH-1:0] POST_M1 = ADDR_WIDTH'(POST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_FILL,
    S_WAIT_TRIG,
    S_POST_FILL,
    S_READOUT
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH-1:0] r_trig_addr;
  logic [ADDR_WIDTH-1:0] r_pre_cnt;
  logic [ADDR_WIDTH-1:0] r_post_cnt;
  logic                  r_busy;
  logic [ADDR_WIDTH:0]   r_iss;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_fifo [2];
  logic                  r_head;
  logic                  r_tail;
  logic [1:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_out_cnt;

  logic                  w_fill;
  logic                  w_wr;
  logic                  w_trig_hit;
  logic                  w_post_done;
  logic                  w_pop;
  logic                  w_issue;
  logic [2:0]            w_pend;

  assign w_fill      = (r_state == S_PRE_FILL) || (r_state == S_WAIT_TRIG) ||
                       (r_state == S_POST_FILL);
  assign w_wr        = din_valid & w_fill;
  assign w_trig_hit  = (r_state == S_WAIT_TRIG) & w_wr & trig;
  assign w_post_done = (r_state == S_POST_FILL) & w_wr & (r_post_cnt == POST_M1);
  assign w_pop       = (r_cnt != 2'd0) & dout_ready;
  assign w_pend      = 3'(r_cnt) + 3'(r_inflight);
  // Counting this cycle's pop as free space keeps 1 sample/clk with only two skid entries.
  assign w_issue     = (r_state == S_READOUT) & ~r_iss[ADDR_WIDTH] &
                       (w_pend < (3'(SKID) + 3'(w_pop)));

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:      if (arm) w_state_nx = S_PRE_FILL;
      S_PRE_FILL:  if (w_wr && (r_pre_cnt == PRE_M1)) w_state_nx = S_WAIT_TRIG;
      S_WAIT_TRIG: if (w_trig_hit) w_state_nx = (POST_LEN == 1) ? S_READOUT : S_POST_FILL;
      S_POST_FILL: if (w_post_done) w_state_nx = S_READOUT;
      S_READOUT:   if (w_pop && (r_out_cnt == '1)) w_state_nx = S_IDLE;
      default:     w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx != S_IDLE);
    end
  end

  // Write side: pointer, fill counters, trigger capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_trig_addr <= '0;
    end else begin
      if ((r_state == S_IDLE) && arm) begin
        r_wptr     <= '0;
        r_pre_cnt  <= '0;
        r_post_cnt <= '0;
      end else if (w_wr) begin
        r_wptr <= r_wptr + ADDR_WIDTH'(1);
      end
      if ((r_state == S_PRE_FILL) && w_wr) r_pre_cnt <= r_pre_cnt + ADDR_WIDTH'(1);
      if (w_trig_hit) begin
        r_trig_addr <= r_wptr;
        r_post_cnt  <= ADDR_WIDTH'(1);
      end else if ((r_state == S_POST_FILL) && w_wr) begin
        r_post_cnt <= r_post_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr <= '0;
    end else if (w_trig_hit && (POST_LEN == 1)) begin
      r_rptr <= r_wptr - PRE_A;
    end else if (w_post_done) begin
      r_rptr <= r_trig_addr - PRE_A;
    end else if (w_issue) begin
      r_rptr <= r_rptr + ADDR_WIDTH'(1);
    end
  end

  // Read side: issue counter, in-flight flag, 2-entry skid FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss      <= '0;
      r_inflight <= 1'b0;
      r_fifo     <= '{default: '0};
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_cnt      <= '0;
      r_out_cnt  <= '0;
    end else if (r_state != S_READOUT) begin
      r_iss      <= '0;
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_cnt      <= '0;
      r_out_cnt  <= '0;
    end else begin
      if (w_issue) r_iss <= r_iss + (ADDR_WIDTH + 1)'(1);
      r_inflight <= w_issue;
      if (r_inflight) begin
        r_fifo[r_tail] <= ram_rd_data;
        r_tail         <= ~r_tail;
      end
      if (w_pop) begin
        r_head    <= ~r_head;
        r_out_cnt <= r_out_cnt + ADDR_WIDTH'(1);
      end
      r_cnt <= r_cnt + 2'(r_inflight) - 2'(w_pop);
    end
  end

  assign ram_wr_data = din;
  assign ram_wr_addr = r_wptr;
  assign ram_wr_en   = w_wr;
  assign ram_rd_addr = r_rptr;
  assign dout        = r_fifo[r_head];
  assign dout_valid  = (r_cnt != 2'd0);
  assign dout_last   = (r_cnt != 2'd0) & (r_out_cnt == '1);
  assign busy        = r_busy;
  assign trig_addr   = r_trig_addr;

endmodule

// File: tb/tb_ram_frame_capture.sv
// Directed bench for ram_frame_capture with a behavioural 1024x8 registered-read RAM.
module tb_ram_frame_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arm;
  logic [7:0] din;
  logic       din_valid;
  logic       trig;
  logic [7:0] ram_wr_data;
  logic [9:0] ram_wr_addr;
  logic       ram_wr_en;
  logic [9:0] ram_rd_addr;
  logic [7:0] ram_rd_data;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       dout_last;
  logic       busy;
  logic [9:0] trig_addr;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem  [1024];
  logic [7:0] hist [4096];

  typedef struct packed {
    int   en_err;
    int   addr_err;
    int   nwr;
    logic busy;
  } fill_res_t;

  typedef struct packed {
    int         k;
    int         data_err;
    int         last_err;
    int         stab_err;
    int         wr_err;
    int         first_j;
    logic [7:0] first_v;
    logic [7:0] last_v;
    logic       busy;
    logic       valid;
  } rd_res_t;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  ram_frame_capture #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(8),
    .PRE_TRIG  (256),
    .RD_LATENCY(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .din        (din),
    .din_valid  (din_valid),
    .trig       (trig),
    .ram_wr_data(ram_wr_data),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_en  (ram_wr_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .trig_addr  (trig_addr)
  );

  function automatic logic [7:0] pat(input int mode, input int n);
    case (mode)
      0:       return 8'(n);
      1:       return 8'(n * 29 + (n / 256) * 113 + 7);
      default: return ~8'(n * 29 + (n / 256) * 113 + 7);
    endcase
  endfunction

  // Arm, then stream samples until trig_idx+768 valid samples have been offered.
  task automatic run_fill(input int trig_idx, input int early, input int mode, input bit gaps,
                          output fill_res_t r);
    int n = 0;
    int cyc = 0;
    int total = trig_idx + 768;
    logic v;
    r = '0;
    @(negedge clk);
    arm = 1'b1; din_valid = 1'b0; trig = 1'b0;
    @(negedge clk);
    arm = 1'b0;
    while (n < total && cyc < 20000) begin
      v = gaps ? ((cyc % 3) != 2) : 1'b1;
      din_valid = v;
      din = pat(mode, n);
      trig = v && (n == trig_idx || n == early);
      arm = (n == trig_idx + 100);
      #1;
      if (ram_wr_en !== v) r.en_err++;
      if (v && ram_wr_addr !== 10'(n % 1024)) r.addr_err++;
      if (v) begin
        hist[n] = din;
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    arm = 1'b0; trig = 1'b0; din_valid = 1'b1; din = 8'hEE;
    r.nwr = n;
    r.busy = busy;
  endtask

  // Drain up to stop_at transfers starting at hist[first]; entered at the negedge after READOUT entry.
  task automatic run_read(input int first, input bit rnd, input int stop_at, output rd_res_t r);
    int j = 0;
    logic stalled = 1'b0;
    logic [7:0] held = '0;
    r = '0;
    r.first_j = -1;
    while (r.k < stop_at && j < 8000) begin
      dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      arm = (j == 10);
      #1;
      if (ram_wr_en !== 1'b0) r.wr_err++;
      if (stalled && (dout_valid !== 1'b1 || dout !== held)) r.stab_err++;
      stalled = 1'b0;
      if (dout_valid === 1'b1) begin
        if (r.first_j < 0) begin
          r.first_j = j;
          r.first_v = dout;
        end
        if (r.k == 1023) r.last_v = dout;
        if (dout !== hist[first + r.k]) r.data_err++;
        if (dout_last !== (r.k == 1023)) r.last_err++;
        if (dout_ready) r.k++;
        else begin
          stalled = 1'b1;
          held = dout;
        end
      end else if (dout_last !== 1'b0) begin
        r.last_err++;
      end
      j++;
      @(negedge clk);
    end
    arm = 1'b0;
    dout_ready = 1'b1;
    r.busy = busy;
    r.valid = dout_valid;
  endtask

  task automatic test_reset();
    din_valid = 1'b1; din = 8'h5A;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", dout_valid); end
    n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL rst_dout: got %h want 00", dout); end
    n_cmp++; if (trig_addr !== 10'd0) begin n_err++; $display("FAIL rst_trig_addr: got %0d want 0", trig_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (ram_wr_en !== 1'b0) begin n_err++; $display("FAIL idle_wr_en: got %b want 0", ram_wr_en); end
    n_cmp++; if (dout_last !== 1'b0) begin n_err++; $display("FAIL idle_last: got %b want 0", dout_last); end
  endtask

  task automatic test_basic();
    fill_res_t f;
    rd_res_t   r;
    run_fill(600, -1, 0, 1'b0, f);
    n_cmp++; if (f.addr_err !== 0) begin n_err++; $display("FAIL t1_wr_addr: errors %0d want 0", f.addr_err); end
    n_cmp++; if (f.en_err !== 0) begin n_err++; $display("FAIL t1_wr_en: errors %0d want 0", f.en_err); end
    n_cmp++; if (f.busy !== 1'b1) begin n_err++; $display("FAIL t1_busy: got %b want 1", f.busy); end
    n_cmp++; if (trig_addr !== 10'd600) begin n_err++; $display("FAIL t1_trig_addr: got %0d want 600", trig_addr); end
    run_read(344, 1'b0, 1024, r);
    n_cmp++; if (r.k !== 1024) begin n_err++; $display("FAIL t1_count: got %0d want 1024", r.k); end
    n_cmp++; if (r.first_j !== 2) begin n_err++; $display("FAIL t1_latency: got %0d want 2", r.first_j); end
    n_cmp++; if (r.first_v !== 8'd88) begin n_err++; $display("FAIL t1_first: got %0d want 88", r.first_v); end
    n_cmp++; if (r.last_v !== 8'd87) begin n_err++; $display("FAIL t1_last_val: got %0d want 87", r.last_v); end
    n_cmp++; if (r.data_err !== 0) begin n_err++; $display("FAIL t1_data: errors %0d want 0", r.data_err); end
    n_cmp++; if (r.last_err !== 0) begin n_err++; $display("FAIL t1_dout_last: errors %0d want 0", r.last_err); end
    n_cmp++; if (r.wr_err !== 0) begin n_err++; $display("FAIL t1_wr_blocked: errors %0d want 0", r.wr_err); end
    n_cmp++; if (r.busy !== 1'b0 || r.valid !== 1'b0) begin n_err++; $display("FAIL t1_idle: busy %b valid %b want 0 0", r.busy, r.valid); end
  endtask

  task automatic test_early_trig();
    fill_res_t f;
    rd_res_t   r;
    run_fill(300, 100, 1, 1'b0, f);
    n_cmp++; if (trig_addr !== 10'd300) begin n_err++; $display("FAIL t2_trig_addr: got %0d want 300", trig_addr); end
    run_read(44, 1'b0, 1024, r);
    n_cmp++; if (r.k !== 1024) begin n_err++; $display("FAIL t2_count: got %0d want 1024", r.k); end
    n_cmp++; if (r.data_err !== 0) begin n_err++; $display("FAIL t2_data: errors %0d want 0", r.data_err); end
  endtask

  task automatic test_wrap();
    fill_res_t f;
    rd_res_t   r;
    run_fill(3000, -1, 1, 1'b0, f);
    n_cmp++; if (f.addr_err !== 0) begin n_err++; $display("FAIL t3_wr_addr: errors %0d want 0", f.addr_err); end
    n_cmp++; if (trig_addr !== 10'd952) begin n_err++; $display("FAIL t3_trig_addr: got %0d want 952", trig_addr); end
    run_read(2744, 1'b0, 1024, r);
    n_cmp++; if (r.k !== 1024) begin n_err++; $display("FAIL t3_count: got %0d want 1024", r.k); end
    n_cmp++; if (r.data_err !== 0) begin n_err++; $display("FAIL t3_data: errors %0d want 0", r.data_err); end
    n_cmp++; if (r.last_err !== 0) begin n_err++; $display("FAIL t3_dout_last: errors %0d want 0", r.last_err); end
  endtask

  task automatic test_backpressure();
    fill_res_t f;
    rd_res_t   r;
    run_fill(400, -1, 1, 1'b0, f);
    run_read(144, 1'b1, 1024, r);
    n_cmp++; if (r.k !== 1024) begin n_err++; $display("FAIL t4_count: got %0d want 1024", r.k); end
    n_cmp++; if (r.data_err !== 0) begin n_err++; $display("FAIL t4_order: errors %0d want 0", r.data_err); end
    n_cmp++; if (r.stab_err !== 0) begin n_err++; $display("FAIL t4_stable: errors %0d want 0", r.stab_err); end
    n_cmp++; if (r.last_err !== 0) begin n_err++; $display("FAIL t4_dout_last: errors %0d want 0", r.last_err); end
    n_cmp++; if (r.busy !== 1'b0) begin n_err++; $display("FAIL t4_idle: busy %b want 0", r.busy); end
  endtask

  task automatic test_gaps();
    fill_res_t f;
    rd_res_t   r;
    run_fill(500, -1, 1, 1'b1, f);
    n_cmp++; if (f.en_err !== 0) begin n_err++; $display("FAIL t5_wr_en: errors %0d want 0", f.en_err); end
    n_cmp++; if (f.addr_err !== 0) begin n_err++; $display("FAIL t5_wr_addr: errors %0d want 0", f.addr_err); end
    n_cmp++; if (f.nwr !== 1268) begin n_err++; $display("FAIL t5_nwr: got %0d want 1268", f.nwr); end
    n_cmp++; if (trig_addr !== 10'd500) begin n_err++; $display("FAIL t5_trig_addr: got %0d want 500", trig_addr); end
    run_read(244, 1'b0, 1024, r);
    n_cmp++; if (r.k !== 1024) begin n_err++; $display("FAIL t5_count: got %0d want 1024", r.k); end
    n_cmp++; if (r.data_err !== 0) begin n_err++; $display("FAIL t5_data: errors %0d want 0", r.data_err); end
    n_cmp++; if (r.wr_err !== 0) begin n_err++; $display("FAIL t5_wr_blocked: errors %0d want 0", r.wr_err); end
  endtask

  task automatic test_reset_mid();
    fill_res_t f;
    rd_res_t   r;
    run_fill(256, -1, 1, 1'b0, f);
    n_cmp++; if (trig_addr !== 10'd256) begin n_err++; $display("FAIL t6_trig_addr: got %0d want 256", trig_addr); end
    run_read(0, 1'b0, 500, r);
    n_cmp++; if (r.k !== 500 || r.data_err !== 0) begin n_err++; $display("FAIL t6_partial: count %0d errors %0d want 500 0", r.k, r.data_err); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t6_rst_busy: got %b want 0", busy); end
    n_cmp++; if (dout_valid !== 1'b0 || dout_last !== 1'b0) begin n_err++; $display("FAIL t6_rst_valid: valid %b last %b want 0 0", dout_valid, dout_last); end
    n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL t6_rst_dout: got %h want 00", dout); end
    n_cmp++; if (trig_addr !== 10'd0) begin n_err++; $display("FAIL t6_rst_trig_addr: got %0d want 0", trig_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    run_fill(256, -1, 2, 1'b0, f);
    run_read(0, 1'b0, 1024, r);
    n_cmp++; if (r.k !== 1024) begin n_err++; $display("FAIL t6_count: got %0d want 1024", r.k); end
    n_cmp++; if (r.data_err !== 0) begin n_err++; $display("FAIL t6_data: errors %0d want 0", r.data_err); end
    n_cmp++; if (r.last_err !== 0) begin n_err++; $display("FAIL t6_dout_last: errors %0d want 0", r.last_err); end
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; din = '0; din_valid = 1'b0; trig = 1'b0; dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_early_trig();
    test_wrap();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
